// File: rtl/sm4_pipe_hs.sv
// sm4_pipe_hs: SM4 block pipeline with RPS rounds per stage (STAGES = 32/RPS).
// It has a valid/ready handshake with a full-pipeline stall, a sideband tag,
// a synchronous flush and occupancy reporting. Encrypt or decrypt is chosen
// only by the order of the round keys.
// Handshake: a block transfers on a rising edge where valid and ready are both 1.
// in_ready_o depends only on the output-side state, out_ready_i and flush_i;
// it never depends on in_valid_i.
// Optional macro SM4_KEY_REG_EN adds an internal round-key register. Its ports
// key_load_i and key_err_o exist only in that build.
module sm4_pipe_hs #(
   parameter int RPS   = 1,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1023:0]    rk_i,
`ifdef SM4_KEY_REG_EN
   input  logic             key_load_i,
   output logic             key_err_o,
`endif
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [127:0]     in_data_i,
   input  logic [TAG_W-1:0] in_tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [127:0]     out_data_o,
   output logic [TAG_W-1:0] out_tag_o,
   input  logic             flush_i,
   output logic             busy_o,
   output logic [5:0]       occ_o
);
   localparam int STAGES = 32 / RPS;

   if (RPS != 1 && RPS != 2 && RPS != 4 && RPS != 8 && RPS != 16 && RPS != 32) begin : g_bad_rps
      $error("sm4_pipe_hs: RPS must be one of 1, 2, 4, 8, 16, 32");
   end

   localparam logic [2047:0] SBOX_TBL = {
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   function automatic logic [7:0] sbox(input logic [7:0] a);
      return SBOX_TBL[2047 - 8*int'(a) -: 8];
   endfunction

   // Mixer T: byte-wise S-box followed by the linear diffusion L
   function automatic logic [31:0] sm4_t(input logic [31:0] a);
      logic [31:0] b;
      b = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
      return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
   endfunction

   // One round: {X0,X1,X2,X3} -> {X1,X2,X3,X0 ^ T(X1^X2^X3^rk)}
   function automatic logic [127:0] sm4_round(input logic [127:0] x, input logic [31:0] rk);
      return {x[95:0], x[127:96] ^ sm4_t(x[95:64] ^ x[63:32] ^ x[31:0] ^ rk)};
   endfunction

   logic [127:0]     data_q [STAGES];
   logic [127:0]     data_d [STAGES];
   logic [TAG_W-1:0] tag_q  [STAGES];
   logic [TAG_W-1:0] tag_d  [STAGES];
   logic [STAGES-1:0] valid_q, valid_d;
   logic [5:0]       occ_q, occ_d;
   logic [127:0]     stage_in  [STAGES];
   logic [127:0]     stage_out [STAGES];
   logic [1023:0]    rk_use;
   logic             adv, acc, out_hs;

   assign out_valid_o = valid_q[STAGES-1];
   assign out_data_o  = data_q[STAGES-1];
   assign out_tag_o   = tag_q[STAGES-1];
   assign adv         = ~out_valid_o | out_ready_i;
   assign in_ready_o  = adv & ~flush_i;
   assign acc         = in_valid_i & in_ready_o;
   assign out_hs      = out_valid_o & out_ready_i;
   assign occ_o       = occ_q;
   assign busy_o      = (occ_q != 6'd0);

`ifdef SM4_KEY_REG_EN
   logic [1023:0] key_q, key_d;
   logic          key_err_q, key_err_d;
   logic          key_ok;

   // A key load is taken only when the pipe is empty and nothing enters on this edge
   assign key_ok = key_load_i & ~busy_o & ~acc;

   // Key register and sticky error next state
   always_comb begin
      key_d     = key_q;
      key_err_d = key_err_q;
      if (key_ok) key_d = rk_i;
      if (key_load_i & ~key_ok) key_err_d = 1'b1;
      if (flush_i) key_err_d = 1'b0;
   end

   // Key register and sticky error flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_q     <= '0;
         key_err_q <= 1'b0;
      end else begin
         key_q     <= key_d;
         key_err_q <= key_err_d;
      end
   end

   assign rk_use    = key_q;
   assign key_err_o = key_err_q;
`else
   assign rk_use = rk_i;
`endif

   assign stage_in[0] = in_data_i;
   for (genvar s = 1; s < STAGES; s++) begin : g_link
      assign stage_in[s] = data_q[s-1];
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic [127:0] rnd;

      // Chain RPS rounds using round keys rk[s*RPS] .. rk[s*RPS+RPS-1]
      always_comb begin
         logic [127:0] x;
         x = stage_in[s];
         for (int r = 0; r < RPS; r++) begin
            x = sm4_round(x, rk_use[1023 - 32*(s*RPS + r) -: 32]);
         end
         rnd = x;
      end

      // The last stage applies the final word reversal so the output is registered
      if (s == STAGES-1) begin : g_rev
         assign stage_out[s] = {rnd[31:0], rnd[63:32], rnd[95:64], rnd[127:96]};
      end else begin : g_fwd
         assign stage_out[s] = rnd;
      end
   end

   // Pipeline next state: whole pipe shifts on advance, flush clears every valid bit
   always_comb begin
      valid_d = valid_q;
      occ_d   = occ_q;
      for (int s = 0; s < STAGES; s++) begin
         data_d[s] = data_q[s];
         tag_d[s]  = tag_q[s];
      end
      if (adv) begin
         valid_d[0] = acc;
         data_d[0]  = stage_out[0];
         tag_d[0]   = in_tag_i;
         for (int s = 1; s < STAGES; s++) begin
            valid_d[s] = valid_q[s-1];
            data_d[s]  = stage_out[s];
            tag_d[s]   = tag_q[s-1];
         end
      end
      if (acc & ~out_hs) occ_d = occ_q + 6'd1;
      else if (~acc & out_hs) occ_d = occ_q - 6'd1;
      if (flush_i) begin
         valid_d = '0;
         occ_d   = 6'd0;
      end
   end

   // Pipeline flops, all cleared by the asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         occ_q   <= 6'd0;
         for (int s = 0; s < STAGES; s++) begin
            data_q[s] <= '0;
            tag_q[s]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         occ_q   <= occ_d;
         for (int s = 0; s < STAGES; s++) begin
            data_q[s] <= data_d[s];
            tag_q[s]  <= tag_d[s];
         end
      end
   end

endmodule

// File: tb/tb_sm4_pipe_hs.sv
// tb_sm4_pipe_hs: directed checks of sm4_pipe_hs against the published SM4 vector.
module tb_sm4_pipe_hs;
   localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;
   localparam logic [1023:0] RK_ENC = {
      256'hf12186f9_41662b61_5a6ab19a_7ba92077_367360f4_776a0c61_b6bb89b3_24763151,
      256'ha520307c_b7584dbd_c30753ed_7ee55b57_6988608c_30d895b7_44ba14af_104495a1,
      256'hd120b428_73b55fa3_cc874966_92244439_e89e641f_98ca015a_c7159060_99e1fd2e,
      256'hb79bd80c_1d2115b0_0e228aeb_f1780c81_428d3654_62293496_01cf72e5_9124a012
   };

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // main DUT (RPS=1)
   logic [1023:0] rk;
   logic          in_valid, in_ready, out_valid, out_ready, flush, busy;
   logic [127:0]  in_data, out_data;
   logic [7:0]    in_tag, out_tag;
   logic [5:0]    occ;
   logic          key_load, key_err;

   sm4_pipe_hs #(.RPS(1), .TAG_W(8)) u_dut (
      .clk(clk), .rst(rst), .rk_i(rk),
`ifdef SM4_KEY_REG_EN
      .key_load_i(key_load), .key_err_o(key_err),
`endif
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_tag_i(in_tag),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_tag_o(out_tag),
      .flush_i(flush), .busy_o(busy), .occ_o(occ)
   );

   // sweep DUTs, RPS = 2,4,8,16,32, shared inputs
   logic [1023:0] s_rk;
   logic          s_valid, s_key_load;
   logic [127:0]  s_data;
   logic [7:0]    s_tag;
   logic          s_ir [5];
   logic          s_ov [5];
   logic [127:0]  s_od [5];
   logic [7:0]    s_ot [5];
   logic          s_busy [5];
   logic [5:0]    s_occ [5];
   logic          s_kerr [5];

   for (genvar k = 0; k < 5; k++) begin : g_sweep
      sm4_pipe_hs #(.RPS(2 << k), .TAG_W(8)) u_sw (
         .clk(clk), .rst(rst), .rk_i(s_rk),
`ifdef SM4_KEY_REG_EN
         .key_load_i(s_key_load), .key_err_o(s_kerr[k]),
`endif
         .in_valid_i(s_valid), .in_ready_o(s_ir[k]), .in_data_i(s_data), .in_tag_i(s_tag),
         .out_valid_o(s_ov[k]), .out_ready_i(1'b1), .out_data_o(s_od[k]), .out_tag_o(s_ot[k]),
         .flush_i(1'b0), .busy_o(s_busy[k]), .occ_o(s_occ[k])
      );
   end

   // scoreboard state
   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q[$];
   logic [1023:0] rk_enc, rk_dec;
   logic [5:0] occ_after_acc;

   task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   // driver: present the round keys (and latch them when the key register exists)
   task automatic load_key(input logic [1023:0] k);
      @(negedge clk);
      rk = k;
`ifdef SM4_KEY_REG_EN
      key_load = 1'b1;
      @(posedge clk);
      @(negedge clk);
      key_load = 1'b0;
`endif
   endtask

   // driver: send one block with out_ready=1, return edges-to-output and the result
   task automatic send_one(input logic [127:0] d, input logic [7:0] t,
                           output int lat, output logic [127:0] od, output logic [7:0] ot);
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_tag = t; out_ready = 1'b1;
      #1 check("send_in_ready", in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      occ_after_acc = occ;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      od = out_data;
      ot = out_tag;
   endtask

   initial begin
      int lat, sent, recv, cyc, seen;
      logic [127:0] od, hold_d;
      logic [7:0] ot, hold_t, tg, et;
      logic held, acc_now, hs_now;
      int exp_lat [5];
      int sw_lat [5];
      logic [127:0] sw_d [5];
      logic [7:0] sw_t [5];

      exp_lat = '{16, 8, 4, 2, 1};
      rk_enc = RK_ENC;
      for (int i = 0; i < 32; i++) rk_dec[1023 - 32*i -: 32] = rk_enc[32*i + 31 -: 32];

      in_valid = 0; in_data = '0; in_tag = '0; out_ready = 0; flush = 0; key_load = 0;
      rk = rk_enc; s_rk = rk_dec; s_valid = 0; s_data = '0; s_tag = '0; s_key_load = 0;
      key_err = 1'b0;

      // ---- reset state
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_occ", occ, 6'd0);
      check("rst_out_data", out_data, 128'h0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_out_tag", out_tag, 8'h00);
      load_key(rk_enc);

      // ---- encrypt, RPS=1
      send_one(PT, 8'h5a, lat, od, ot);
      check("enc_occ_after_accept", occ_after_acc, 6'd1);
      check("enc_latency", lat, 32);
      check("enc_data", od, CT);
      check("enc_tag", ot, 8'h5a);
      @(posedge clk);
      @(negedge clk);
      check("enc_drained_valid", out_valid, 1'b0);
      check("enc_drained_occ", occ, 6'd0);

      // ---- back-pressure, 40 blocks, random out_ready
      sent = 0; recv = 0; cyc = 0; held = 0; hold_d = '0; hold_t = '0;
      while (recv < 40 && cyc < 3000) begin
         @(negedge clk);
         tg = 8'h40 + 8'(sent);
         in_valid = (sent < 40); in_data = PT; in_tag = tg;
         out_ready = 1'($urandom_range(0, 1));
         #1;
         if (held) begin
            check("bp_hold_data", out_data, hold_d);
            check("bp_hold_tag", out_tag, hold_t);
         end
         check("bp_occ_le_32", (occ <= 6'd32), 1'b1);
         if (occ == 6'd32 && !out_ready) check("bp_full_in_ready", in_ready, 1'b0);
         held = out_valid && !out_ready;
         hold_d = out_data; hold_t = out_tag;
         acc_now = in_valid && in_ready;
         hs_now = out_valid && out_ready;
         if (hs_now) begin
            if (exp_q.size() == 0) begin
               check("bp_unexpected_output", 1'b1, 1'b0);
            end else begin
               et = exp_q.pop_front();
               check("bp_tag_order", out_tag, et);
               check("bp_data", out_data, CT);
            end
            recv++;
         end
         @(posedge clk);
         if (acc_now) begin
            exp_q.push_back(tg);
            sent++;
         end
         cyc++;
      end
      @(negedge clk);
      in_valid = 0;
      check("bp_received", recv, 40);
      check("bp_queue_empty", exp_q.size(), 0);
      @(negedge clk);
      check("bp_final_occ", occ, 6'd0);

      // ---- flush with 10 in flight
      out_ready = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1; in_data = PT; in_tag = 8'h80 + 8'(i);
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1; flush = 1;
      #1 check("flush_pre_occ", occ, 6'd10);
      check("flush_in_ready", in_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      flush = 0; in_valid = 0; out_ready = 1;
      check("flush_occ", occ, 6'd0);
      check("flush_busy", busy, 1'b0);
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("flush_no_output", seen, 0);
      send_one(PT, 8'hc3, lat, od, ot);
      check("flush_next_latency", lat, 32);
      check("flush_next_data", od, CT);
      check("flush_next_tag", ot, 8'hc3);

      // ---- asynchronous reset with 20 in flight
      @(negedge clk);
      out_ready = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in_valid = 1; in_data = PT; in_tag = 8'h20 + 8'(i);
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 0;
      repeat (15) @(posedge clk);
      @(negedge clk);
      #1 check("mid_pre_out_valid", out_valid, 1'b1);
      check("mid_pre_occ", occ, 6'd20);
      #2 rst = 1'b1;
      #1 check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_occ", occ, 6'd0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_out_data", out_data, 128'h0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("mid_post_in_ready", in_ready, 1'b1);
      load_key(rk_enc);
      send_one(PT, 8'h77, lat, od, ot);
      check("mid_post_latency", lat, 32);
      check("mid_post_data", od, CT);
      check("mid_post_tag", ot, 8'h77);

      // ---- decrypt sweep RPS = 2,4,8,16,32
      @(negedge clk);
      s_rk = rk_dec;
`ifdef SM4_KEY_REG_EN
      s_key_load = 1;
      @(posedge clk);
      @(negedge clk);
      s_key_load = 0;
`endif
      @(negedge clk);
      s_valid = 1; s_data = CT; s_tag = 8'h3c;
      for (int k = 0; k < 5; k++) begin
         sw_lat[k] = 0; sw_d[k] = '0; sw_t[k] = '0;
      end
      @(posedge clk);
      @(negedge clk);
      s_valid = 0;
      for (int e = 1; e <= 20; e++) begin
         for (int k = 0; k < 5; k++) begin
            if (s_ov[k] && sw_lat[k] == 0) begin
               sw_lat[k] = e; sw_d[k] = s_od[k]; sw_t[k] = s_ot[k];
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      for (int k = 0; k < 5; k++) begin
         check($sformatf("sweep_latency_rps%0d", 2 << k), sw_lat[k], exp_lat[k]);
         check($sformatf("sweep_data_rps%0d", 2 << k), sw_d[k], PT);
         check($sformatf("sweep_tag_rps%0d", 2 << k), sw_t[k], 8'h3c);
      end

`ifdef SM4_KEY_REG_EN
      // ---- key register: load while busy is refused and flagged
      @(negedge clk);
      in_valid = 1; in_data = PT; in_tag = 8'h91; out_ready = 1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0; rk = rk_dec; key_load = 1;
      lat = 1;
      @(posedge clk);
      @(negedge clk);
      key_load = 0;
      lat++;
      check("key_err_busy_load", key_err, 1'b1);
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check("key_busy_old_key_data", out_data, CT);
      check("key_busy_tag", out_tag, 8'h91);
      @(posedge clk);
      @(negedge clk);
      check("key_err_sticky", key_err, 1'b1);
      flush = 1;
      @(posedge clk);
      @(negedge clk);
      flush = 0;
      check("key_err_flush_clear", key_err, 1'b0);
      load_key(rk_dec);
      check("key_err_idle_load", key_err, 1'b0);
      send_one(CT, 8'h92, lat, od, ot);
      check("key_new_latency", lat, 32);
      check("key_new_data", od, PT);
      check("key_new_tag", ot, 8'h92);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
